// File: rtl/tlul_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tlul_rr_arbiter
//
// Round-robin arbiter that lets NumHosts TL-UL hosts share one TL-UL device
// port. A-channel requests are granted one transaction at a time. The index of
// the owning host of every accepted transaction is pushed into an in-order
// ownership FIFO, and D-channel responses are steered back to the FIFO head.
// The device must therefore answer strictly in order.
//
// Parameters:
//   NumHosts        number of requesting hosts (2..8)
//   MaxOutstanding  accepted-but-unanswered transactions, also FIFO depth (1..8)
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   tl_h_i/tl_h_o  per-host TL-UL request / response
//   tl_d_o/tl_d_i  device-side TL-UL request / response
//   outstanding_o  number of transactions currently in flight
//   err_o          sticky: a device response arrived with no owner
//
// Optional feature (define TLUL_ARB_PERF_EN):
//   perf_grant_o[i]  saturating count of accepted requests from host i
//   perf_stall_o[i]  saturating count of cycles host i waited (a_valid, !a_ready)
// Without the macro these ports and counters do not exist.
// -----------------------------------------------------------------------------
package tlul_rr_arbiter_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_rr_arbiter
  import tlul_rr_arbiter_pkg::*;
#(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  tl_h2d_t                              tl_h_i [NumHosts],
  output tl_d2h_t                              tl_h_o [NumHosts],
  output tl_h2d_t                              tl_d_o,
  input  tl_d2h_t                              tl_d_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 err_o
`ifdef TLUL_ARB_PERF_EN
  ,
  output logic [NumHosts-1:0][31:0]            perf_grant_o,
  output logic [NumHosts-1:0][31:0]            perf_stall_o
`endif
);

  localparam int HostW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);

  // (base + off) mod NumHosts, off < NumHosts
  function automatic logic [HostW-1:0] host_add(input logic [HostW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumHosts) s = s - NumHosts;
    return HostW'(s);
  endfunction

  // FIFO pointer increment mod MaxOutstanding
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (int'(p) >= MaxOutstanding - 1) return '0;
    return p + PtrW'(1);
  endfunction

  logic [HostW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HostW-1:0] lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HostW-1:0] fifo_q [MaxOutstanding];
  logic [HostW-1:0] fifo_d [MaxOutstanding];

  logic [HostW-1:0]    grant;
  logic                grant_valid;
  logic [HostW-1:0]    head;
  logic                not_full;
  logic                fifo_empty;
  logic                dev_a_valid;
  logic                accept;
  logic                head_d_ready;
  logic                push;
  logic                pop;
  logic [NumHosts-1:0] host_a_ready;

  // Grant: a stalled request stays locked to its host so the device-side
  // A fields cannot change while a_valid is high; otherwise scan from rr_ptr.
  always_comb begin
    grant       = rr_ptr_q;
    grant_valid = 1'b0;
    if (lock_q) begin
      grant       = lock_idx_q;
      grant_valid = tl_h_i[lock_idx_q].a_valid;
    end else begin
      for (int k = 0; k < NumHosts; k++) begin
        if (!grant_valid && tl_h_i[host_add(rr_ptr_q, k)].a_valid) begin
          grant_valid = 1'b1;
          grant       = host_add(rr_ptr_q, k);
        end
      end
    end
  end

  assign not_full     = (cnt_q < CntW'(MaxOutstanding));
  assign fifo_empty   = (cnt_q == '0);
  assign head         = fifo_q[rd_ptr_q];
  assign head_d_ready = tl_h_i[head].d_ready;

  assign dev_a_valid = ~rst_i & grant_valid & not_full;
  assign accept      = dev_a_valid & tl_d_i.a_ready;
  assign push        = accept;
  // A same-cycle push into an empty FIFO is not visible here: pop uses the
  // registered count and head only.
  assign pop         = ~rst_i & tl_d_i.d_valid & ~fifo_empty & head_d_ready;

  // Device-side request and host-side responses
  always_comb begin
    tl_d_o         = tl_h_i[grant];
    tl_d_o.a_valid = dev_a_valid;
    // With nothing outstanding a response has no owner; sink it.
    tl_d_o.d_ready = ~rst_i & (fifo_empty | head_d_ready);
    for (int i = 0; i < NumHosts; i++) begin
      host_a_ready[i]   = ~rst_i & tl_d_i.a_ready & not_full & (grant == HostW'(i));
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = host_a_ready[i];
      tl_h_o[i].d_valid = ~rst_i & tl_d_i.d_valid & ~fifo_empty & (head == HostW'(i));
    end
  end

  // Next-state
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    fifo_d     = fifo_q;

    if (accept) begin
      rr_ptr_d         = host_add(grant, 1);
      lock_d           = 1'b0;
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (dev_a_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (~rst_i && tl_d_i.d_valid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

`ifdef TLUL_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  logic [NumHosts-1:0][31:0] perf_grant_q, perf_grant_d;
  logic [NumHosts-1:0][31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_stall_d = perf_stall_q;
    for (int i = 0; i < NumHosts; i++) begin
      if (accept && (grant == HostW'(i))) begin
        perf_grant_d[i] = sat_inc(perf_grant_q[i]);
      end
      if (tl_h_i[i].a_valid && !host_a_ready[i]) begin
        perf_stall_d[i] = sat_inc(perf_stall_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_grant_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_grant_o = perf_grant_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
